// File: rtl/data_in_window.sv
// data_in_window: collects incoming words into a DEPTH-tap window.
// Frame mode emits disjoint groups of DEPTH words; sliding mode emits one
// window per word once the taps are full. Tap 0 holds the newest word.

`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif

// One window tap: loads on enable, clears synchronously, holds otherwise
module data_in_window_tap #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  // clear wins over load; holding when idle keeps unaccepted in_data out
  always_ff @(posedge clk or posedge areset) begin
    if (areset)   q <= '0;
    else if (clr) q <= '0;
    else if (en)  q <= d;
  end
endmodule

module data_in_window #(
  parameter int WIDTH   = `WORD_SIZE,
  parameter int DEPTH   = 3,
  parameter bit SLIDING = 1'b0
) (
  input  logic                       clk,
  input  logic                       areset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH*DEPTH-1:0]     out_data,
  output logic [$clog2(DEPTH+1)-1:0] fill_level
);
  localparam int            FW   = $clog2(DEPTH+1);
  localparam logic [FW-1:0] FULL = FW'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] taps;
  logic [DEPTH-1:0][WIDTH-1:0] tap_d;
  logic [FW-1:0]               fill, fill_nxt;
  logic                        fresh, fresh_nxt;
  logic                        push, pop;

  // Accept only when the held window is gone or leaving this cycle;
  // deliberately independent of in_valid/in_data.
  assign in_ready = !flush && (!fresh || out_ready);
  assign push     = in_valid && in_ready;
  assign pop      = fresh && out_ready;

  // Shift chain: tap 0 takes the new word, tap k takes tap k-1
  genvar k;
  generate
    for (k = 0; k < DEPTH; k++) begin : g_tap
      if (k == 0) begin : g_head
        assign tap_d[k] = in_data;
      end else begin : g_body
        assign tap_d[k] = taps[k-1];
      end
      data_in_window_tap #(.WIDTH(WIDTH)) u_tap (
        .clk    (clk),
        .areset (areset),
        .clr    (flush),
        .en     (push),
        .d      (tap_d[k]),
        .q      (taps[k])
      );
    end
  endgenerate

  // Next fill level / window flag from the push and pop of this cycle
  always_comb begin
    fill_nxt  = fill;
    fresh_nxt = fresh;
    if (push) begin
      // frame mode restarts the group with this word when the window leaves
      if (pop && !SLIDING)  fill_nxt = FW'(1);
      else if (fill != FULL) fill_nxt = fill + 1'b1;
      fresh_nxt = (fill_nxt == FULL);
    end else if (pop) begin
      // sliding mode keeps the taps full; frame mode starts a new group
      fill_nxt  = SLIDING ? FULL : '0;
      fresh_nxt = 1'b0;
    end
  end

  // Occupancy state; flush overrides any transfer on the same edge
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      fill  <= '0;
      fresh <= 1'b0;
    end else if (flush) begin
      fill  <= '0;
      fresh <= 1'b0;
    end else begin
      fill  <= fill_nxt;
      fresh <= fresh_nxt;
    end
  end

  assign out_valid  = fresh;
  assign out_data   = taps;
  assign fill_level = fill;
endmodule

// File: tb/tb_data_in_window.sv
// tb_data_in_window: scoreboard bench for data_in_window.
// Four instances: WIDTH=8 DEPTH=3 frame, DEPTH=3 sliding, and DEPTH=1 in
// both modes sharing one stimulus set. Expected windows are queued when the
// completing word is driven and compared when the window is popped.

module tb_data_in_window;
  logic clk = 1'b0;
  logic areset;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // frame DEPTH=3
  logic f_flush, f_iv, f_or, f_ir, f_ov;
  logic [7:0]  f_id;
  logic [23:0] f_od;
  logic [1:0]  f_fl;
  // sliding DEPTH=3
  logic s_flush, s_iv, s_or, s_ir, s_ov;
  logic [7:0]  s_id;
  logic [23:0] s_od;
  logic [1:0]  s_fl;
  // DEPTH=1, shared inputs; d0 frame, d1 sliding
  logic d_flush, d_iv, d_or;
  logic [7:0] d_id;
  logic d0_ir, d0_ov, d0_fl, d1_ir, d1_ov, d1_fl;
  logic [7:0] d0_od, d1_od;

  logic [23:0] q_f[$];
  logic [23:0] q_s[$];
  logic [7:0]  q_d[$];

  data_in_window #(.WIDTH(8), .DEPTH(3), .SLIDING(1'b0)) u_f (
    .clk(clk), .areset(areset), .flush(f_flush), .in_valid(f_iv), .in_ready(f_ir),
    .in_data(f_id), .out_valid(f_ov), .out_ready(f_or), .out_data(f_od), .fill_level(f_fl));
  data_in_window #(.WIDTH(8), .DEPTH(3), .SLIDING(1'b1)) u_s (
    .clk(clk), .areset(areset), .flush(s_flush), .in_valid(s_iv), .in_ready(s_ir),
    .in_data(s_id), .out_valid(s_ov), .out_ready(s_or), .out_data(s_od), .fill_level(s_fl));
  data_in_window #(.WIDTH(8), .DEPTH(1), .SLIDING(1'b0)) u_d0 (
    .clk(clk), .areset(areset), .flush(d_flush), .in_valid(d_iv), .in_ready(d0_ir),
    .in_data(d_id), .out_valid(d0_ov), .out_ready(d_or), .out_data(d0_od), .fill_level(d0_fl));
  data_in_window #(.WIDTH(8), .DEPTH(1), .SLIDING(1'b1)) u_d1 (
    .clk(clk), .areset(areset), .flush(d_flush), .in_valid(d_iv), .in_ready(d1_ir),
    .in_data(d_id), .out_valid(d1_ov), .out_ready(d_or), .out_data(d1_od), .fill_level(d1_fl));

  // Scoreboard: every pop must match the next queued window
  always @(negedge clk) begin
    logic [23:0] e24;
    logic [7:0]  e8;
    if (areset === 1'b0) begin
      if (f_ov && f_or) begin
        n_checks++;
        if (q_f.size() == 0) begin
          n_fail++; $display("FAIL f_pop: got window %h, expected none", f_od);
        end else begin
          e24 = q_f.pop_front();
          if (f_od !== e24) begin n_fail++; $display("FAIL f_pop: got %h, expected %h", f_od, e24); end
        end
      end
      if (s_ov && s_or) begin
        n_checks++;
        if (q_s.size() == 0) begin
          n_fail++; $display("FAIL s_pop: got window %h, expected none", s_od);
        end else begin
          e24 = q_s.pop_front();
          if (s_od !== e24) begin n_fail++; $display("FAIL s_pop: got %h, expected %h", s_od, e24); end
        end
      end
      if ((d0_ov || d1_ov) && d_or) begin
        n_checks++;
        if (q_d.size() == 0) begin
          n_fail++; $display("FAIL d_pop: got %h/%h, expected none", d0_od, d1_od);
        end else begin
          e8 = q_d.pop_front();
          if ({d0_ov, d1_ov} !== 2'b11 || d0_od !== e8 || d1_od !== e8) begin
            n_fail++;
            $display("FAIL d_pop: got v=%b%b data %h/%h, expected v=11 data %h", d0_ov, d1_ov, d0_od, d1_od, e8);
          end
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    areset = 1'b1;
    {f_flush, f_iv, f_or, s_flush, s_iv, s_or, d_flush, d_iv, d_or} = '0;
    f_id = '0; s_id = '0; d_id = '0;
    #3;
    n_checks++;
    if ({f_ir, f_ov, f_fl, f_od} !== {1'b1, 1'b0, 2'd0, 24'd0}) begin
      n_fail++; $display("FAIL reset_f: got ir=%b ov=%b fl=%0d od=%h, expected 1 0 0 0", f_ir, f_ov, f_fl, f_od);
    end
    n_checks++;
    if ({s_ir, s_ov, s_fl, s_od} !== {1'b1, 1'b0, 2'd0, 24'd0}) begin
      n_fail++; $display("FAIL reset_s: got ir=%b ov=%b fl=%0d od=%h, expected 1 0 0 0", s_ir, s_ov, s_fl, s_od);
    end
    n_checks++;
    if ({d0_ir, d0_ov, d0_fl, d0_od, d1_ir, d1_ov, d1_fl, d1_od} !== {3'b100, 8'd0, 3'b100, 8'd0}) begin
      n_fail++; $display("FAIL reset_d: got d0 %b%b%b %h d1 %b%b%b %h, expected 100 00", d0_ir, d0_ov, d0_fl, d0_od, d1_ir, d1_ov, d1_fl, d1_od);
    end
    #9 areset = 1'b0;
    tick;
    n_checks++;
    if ({f_ir, f_ov, f_fl} !== {1'b1, 1'b0, 2'd0}) begin
      n_fail++; $display("FAIL post_reset_f: got ir=%b ov=%b fl=%0d, expected 1 0 0", f_ir, f_ov, f_fl);
    end
  endtask

  task automatic test_frame_fill;
    f_or = 1'b0;
    for (int i = 0; i < 3; i++) begin
      f_iv = 1'b1; f_id = 8'(8'h11 * (i + 1));
      #1;
      n_checks++;
      if (f_ir !== 1'b1) begin n_fail++; $display("FAIL fill_in_ready: got %b, expected 1", f_ir); end
      tick;
      n_checks++;
      if ({f_ov, f_fl} !== {(i == 2), 2'(i + 1)}) begin
        n_fail++; $display("FAIL fill_level: got ov=%b fl=%0d, expected ov=%b fl=%0d", f_ov, f_fl, (i == 2), i + 1);
      end
    end
    n_checks++;
    if ({f_ir, f_od} !== {1'b0, 24'h112233}) begin
      n_fail++; $display("FAIL fill_window: got ir=%b od=%h, expected ir=0 od=112233", f_ir, f_od);
    end
    f_id = 8'h99;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++;
      if (f_ir !== 1'b0) begin n_fail++; $display("FAIL fill_stall_ready: got %b, expected 0", f_ir); end
      tick;
      n_checks++;
      if ({f_ov, f_fl, f_od} !== {1'b1, 2'd3, 24'h112233}) begin
        n_fail++; $display("FAIL fill_hold: got ov=%b fl=%0d od=%h, expected 1 3 112233", f_ov, f_fl, f_od);
      end
    end
    f_iv = 1'b0;
    q_f.push_back(24'h112233);
    f_or = 1'b1;
    tick;
    f_or = 1'b0;
    n_checks++;
    if ({f_ov, f_fl, f_od} !== {1'b0, 2'd0, 24'h112233}) begin
      n_fail++; $display("FAIL fill_pop_state: got ov=%b fl=%0d od=%h, expected 0 0 112233", f_ov, f_fl, f_od);
    end
    n_checks++;
    if (q_f.size() != 0) begin n_fail++; $display("FAIL fill_queue: got %0d left, expected 0", q_f.size()); end
  endtask

  task automatic test_frame_stream;
    f_iv = 1'b1; f_or = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      f_id = 8'(i);
      if (i % 3 == 0) q_f.push_back({8'(i - 2), 8'(i - 1), 8'(i)});
      #1;
      n_checks++;
      if (f_ir !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready: word %0d got %b, expected 1", i, f_ir); end
      tick;
      n_checks++;
      if ({f_ov, f_fl} !== {(i % 3 == 0), 2'(i % 3 == 0 ? 3 : i % 3)}) begin
        n_fail++; $display("FAIL stream_state: word %0d got ov=%b fl=%0d", i, f_ov, f_fl);
      end
    end
    f_iv = 1'b0;
    tick;
    n_checks++;
    if ({f_ov, f_fl} !== {1'b0, 2'd0} || q_f.size() != 0) begin
      n_fail++; $display("FAIL stream_drain: got ov=%b fl=%0d queue=%0d, expected 0 0 0", f_ov, f_fl, q_f.size());
    end
    f_or = 1'b0;
    f_id = 8'bx;
    tick;
    n_checks++;
    if ({f_ov, f_fl, f_od} !== {1'b0, 2'd0, 24'h040506}) begin
      n_fail++; $display("FAIL idle_x_data: got ov=%b fl=%0d od=%h, expected 0 0 040506", f_ov, f_fl, f_od);
    end
    f_id = 8'h00;
  endtask

  task automatic test_flush;
    f_or = 1'b0;
    f_iv = 1'b1;
    f_id = 8'h21; tick;
    f_id = 8'h22; tick;
    f_flush = 1'b1; f_id = 8'h44;
    #1;
    n_checks++;
    if (f_ir !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b, expected 0", f_ir); end
    tick;
    f_flush = 1'b0;
    n_checks++;
    if ({f_ov, f_fl, f_od} !== {1'b0, 2'd0, 24'd0}) begin
      n_fail++; $display("FAIL flush_clear: got ov=%b fl=%0d od=%h, expected 0 0 000000", f_ov, f_fl, f_od);
    end
    for (int i = 0; i < 3; i++) begin
      f_id = 8'(8'h55 + 8'h11 * i);
      tick;
      n_checks++;
      if ({f_ov, f_fl} !== {(i == 2), 2'(i + 1)}) begin
        n_fail++; $display("FAIL flush_refill: step %0d got ov=%b fl=%0d", i, f_ov, f_fl);
      end
    end
    f_iv = 1'b0;
    n_checks++;
    if (f_od !== 24'h556677) begin n_fail++; $display("FAIL flush_dropped: got %h, expected 556677", f_od); end
    q_f.push_back(24'h556677);
    f_or = 1'b1;
    tick;
    f_or = 1'b0;
    n_checks++;
    if (f_ov !== 1'b0 || q_f.size() != 0) begin
      n_fail++; $display("FAIL flush_pop: got ov=%b queue=%0d, expected 0 0", f_ov, q_f.size());
    end
  endtask

  task automatic test_sliding_stream;
    s_iv = 1'b1; s_or = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      s_id = 8'(i);
      if (i >= 3) q_s.push_back({8'(i - 2), 8'(i - 1), 8'(i)});
      #1;
      n_checks++;
      if (s_ir !== 1'b1) begin n_fail++; $display("FAIL slide_in_ready: word %0d got %b, expected 1", i, s_ir); end
      tick;
      n_checks++;
      if ({s_ov, s_fl} !== {(i >= 3), 2'(i >= 3 ? 3 : i)}) begin
        n_fail++; $display("FAIL slide_state: word %0d got ov=%b fl=%0d", i, s_ov, s_fl);
      end
    end
    s_iv = 1'b0;
    tick;
    n_checks++;
    if ({s_ov, s_fl} !== {1'b0, 2'd3} || q_s.size() != 0) begin
      n_fail++; $display("FAIL slide_pop_only: got ov=%b fl=%0d queue=%0d, expected 0 3 0", s_ov, s_fl, q_s.size());
    end
    s_or = 1'b0;
    s_flush = 1'b1;
    tick;
    s_flush = 1'b0;
    n_checks++;
    if ({s_ov, s_fl, s_od} !== {1'b0, 2'd0, 24'd0}) begin
      n_fail++; $display("FAIL slide_flush: got ov=%b fl=%0d od=%h, expected 0 0 000000", s_ov, s_fl, s_od);
    end
    s_iv = 1'b1;
    for (int i = 1; i <= 3; i++) begin s_id = 8'(i); tick; end
    s_id = 8'h04;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++;
      if (s_ir !== 1'b0) begin n_fail++; $display("FAIL slide_stall_ready: got %b, expected 0", s_ir); end
      tick;
      n_checks++;
      if ({s_ov, s_fl, s_od} !== {1'b1, 2'd3, 24'h010203}) begin
        n_fail++; $display("FAIL slide_hold: got ov=%b fl=%0d od=%h, expected 1 3 010203", s_ov, s_fl, s_od);
      end
    end
    q_s.push_back(24'h010203);
    q_s.push_back(24'h020304);
    s_or = 1'b1;
    #1;
    n_checks++;
    if (s_ir !== 1'b1) begin n_fail++; $display("FAIL slide_resume_ready: got %b, expected 1", s_ir); end
    tick;
    n_checks++;
    if ({s_ov, s_od} !== {1'b1, 24'h020304}) begin
      n_fail++; $display("FAIL slide_next: got ov=%b od=%h, expected 1 020304", s_ov, s_od);
    end
    s_iv = 1'b0;
    tick;
    s_or = 1'b0;
    n_checks++;
    if ({s_ov, s_fl, s_od} !== {1'b0, 2'd3, 24'h020304} || q_s.size() != 0) begin
      n_fail++; $display("FAIL slide_end: got ov=%b fl=%0d od=%h queue=%0d", s_ov, s_fl, s_od, q_s.size());
    end
  endtask

  task automatic test_async_reset;
    f_or = 1'b0;
    f_iv = 1'b1;
    f_id = 8'h01; tick;
    f_id = 8'h02; tick;
    f_iv = 1'b0;
    n_checks++;
    if (f_fl !== 2'd2) begin n_fail++; $display("FAIL areset_pre: got fl=%0d, expected 2", f_fl); end
    #1 areset = 1'b1;
    #1;
    n_checks++;
    if ({f_ir, f_ov, f_fl, f_od} !== {1'b1, 1'b0, 2'd0, 24'd0}) begin
      n_fail++; $display("FAIL areset_async_f: got ir=%b ov=%b fl=%0d od=%h, expected 1 0 0 0", f_ir, f_ov, f_fl, f_od);
    end
    n_checks++;
    if ({s_fl, s_od} !== {2'd0, 24'd0}) begin
      n_fail++; $display("FAIL areset_async_s: got fl=%0d od=%h, expected 0 000000", s_fl, s_od);
    end
    #1 areset = 1'b0;
    tick;
    f_iv = 1'b1;
    for (int i = 7; i <= 9; i++) begin
      f_id = 8'(i);
      tick;
      n_checks++;
      if ({f_ov, f_fl} !== {(i == 9), 2'(i - 6)}) begin
        n_fail++; $display("FAIL areset_refill: word %0d got ov=%b fl=%0d", i, f_ov, f_fl);
      end
    end
    f_iv = 1'b0;
    n_checks++;
    if (f_od !== 24'h070809) begin n_fail++; $display("FAIL areset_window: got %h, expected 070809", f_od); end
    q_f.push_back(24'h070809);
    f_or = 1'b1;
    tick;
    f_or = 1'b0;
  endtask

  task automatic test_depth1;
    d_or = 1'b0; d_iv = 1'b1; d_id = 8'hA5;
    #1;
    n_checks++;
    if ({d0_ir, d1_ir} !== 2'b11) begin n_fail++; $display("FAIL d1_ready_empty: got %b%b, expected 11", d0_ir, d1_ir); end
    tick;
    n_checks++;
    if ({d0_ov, d1_ov, d0_fl, d1_fl, d0_od, d1_od} !== {4'b1111, 8'hA5, 8'hA5}) begin
      n_fail++; $display("FAIL d1_first: got ov=%b%b fl=%b%b od=%h/%h, expected 11 11 a5/a5", d0_ov, d1_ov, d0_fl, d1_fl, d0_od, d1_od);
    end
    d_id = 8'hEE;
    #1;
    n_checks++;
    if ({d0_ir, d1_ir} !== 2'b00) begin n_fail++; $display("FAIL d1_stall_ready: got %b%b, expected 00", d0_ir, d1_ir); end
    tick;
    n_checks++;
    if ({d0_od, d1_od} !== {8'hA5, 8'hA5}) begin n_fail++; $display("FAIL d1_hold: got %h/%h, expected a5/a5", d0_od, d1_od); end
    q_d.push_back(8'hA5);
    q_d.push_back(8'h5A);
    d_or = 1'b1; d_id = 8'h5A;
    #1;
    n_checks++;
    if ({d0_ir, d1_ir} !== 2'b11) begin n_fail++; $display("FAIL d1_ready_pop: got %b%b, expected 11", d0_ir, d1_ir); end
    tick;
    n_checks++;
    if ({d0_ov, d1_ov, d0_od, d1_od} !== {2'b11, 8'h5A, 8'h5A}) begin
      n_fail++; $display("FAIL d1_pop_push: got ov=%b%b od=%h/%h, expected 11 5a/5a", d0_ov, d1_ov, d0_od, d1_od);
    end
    d_iv = 1'b0;
    tick;
    d_or = 1'b0;
    n_checks++;
    if ({d0_ov, d1_ov, d0_fl, d1_fl} !== 4'b0001 || q_d.size() != 0) begin
      n_fail++; $display("FAIL d1_pop_only: got ov=%b%b fl=%b%b queue=%0d, expected 00 01 0", d0_ov, d1_ov, d0_fl, d1_fl, q_d.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_frame_fill;
    test_frame_stream;
    test_flush;
    test_sliding_stream;
    test_async_reset;
    test_depth1;
    tick;
    n_checks++;
    if (q_f.size() != 0 || q_s.size() != 0 || q_d.size() != 0) begin
      n_fail++; $display("FAIL final_queues: got %0d/%0d/%0d left, expected 0/0/0", q_f.size(), q_s.size(), q_d.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
